// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills the S memory with the identity permutation,
// then runs the KSA swap loop over it. Every output is a register.
module rc4_ksa_engine #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   done,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  input  logic [7:0]             q
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_RD_I  = 4'd2,
    S_CAP_I = 4'd3,
    S_RD_J  = 4'd4,
    S_CAP_J = 4'd5,
    S_WR_I  = 4'd6,
    S_WR_J  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t            state_q;
  logic [7:0]        i_q;
  logic [7:0]        j_q;
  logic [KW-1:0]     k_q;
  logic [7:0]        si_q;
  logic [7:0]        address_q;
  logic [7:0]        data_q;
  logic              wren_q;
  logic              done_q;
  logic [7:0]        j_d;

  // Key byte k, counted from the most significant byte of the key.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [KW-1:0] k);
    logic [7:0] r;
    r = 8'd0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (k == KW'(n)) r = key[8*(KEY_BYTES-1-n) +: 8];
    end
    return r;
  endfunction

  assign j_d = j_q + q + key_byte(secret_key, k_q);

  // Control FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      k_q       <= '0;
      si_q      <= 8'd0;
      address_q <= 8'd0;
      data_q    <= 8'd0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wren_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_FILL;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            address_q <= 8'd0;
            data_q    <= 8'd0;
            wren_q    <= 1'b1;
          end
        end
        S_FILL: begin
          if (i_q == 8'd255) begin
            state_q   <= S_RD_I;
            i_q       <= 8'd0;
            k_q       <= '0;
            address_q <= 8'd0;
            wren_q    <= 1'b0;
          end else begin
            i_q       <= i_q + 8'd1;
            address_q <= i_q + 8'd1;
            data_q    <= i_q + 8'd1;
            wren_q    <= 1'b1;
          end
        end
        S_RD_I: state_q <= S_CAP_I;
        S_CAP_I: begin
          si_q      <= q;
          j_q       <= j_d;
          address_q <= j_d;
          state_q   <= S_RD_J;
        end
        S_RD_J: state_q <= S_CAP_J;
        S_CAP_J: begin
          // data_q holds S[j] for the WR_I write; no separate latch is needed.
          address_q <= i_q;
          data_q    <= q;
          wren_q    <= 1'b1;
          state_q   <= S_WR_I;
        end
        S_WR_I: begin
          address_q <= j_q;
          data_q    <= si_q;
          wren_q    <= 1'b1;
          state_q   <= S_WR_J;
        end
        S_WR_J: begin
          wren_q <= 1'b0;
          if (i_q == 8'd255) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            i_q       <= i_q + 8'd1;
            k_q       <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
            address_q <= i_q + 8'd1;
            state_q   <= S_RD_I;
          end
        end
        S_DONE: begin
          wren_q <= 1'b0;
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wren_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address = address_q;
  assign data    = data_q;
  assign wren    = wren_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Scoreboard bench for rc4_ksa_engine: a software RC4 KSA predicts every
// memory write and the final S contents; a monitor checks writes as they occur.
module tb_rc4_ksa_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        done;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic [7:0]  q;

  logic [7:0]  mem   [256];
  logic [7:0]  exp_s [256];
  logic [15:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  rc4_ksa_engine #(.KEY_BYTES(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .done       (done),
    .secret_key (secret_key),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .q          (q)
  );

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (wren === 1'b1) mem[address] <= data;
    q <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference RC4 KSA: queues the expected write stream and records final S.
  function automatic void push_run(input logic [23:0] key);
    int s [256];
    int j, t, kb;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      s[n] = n;
      exp_q.push_back({8'(n), 8'(n)});
    end
    for (int i = 0; i < 256; i++) begin
      kb = (int'(key) >> (8 * (2 - (i % 3)))) & 255;
      j  = (j + s[i] + kb) % 256;
      exp_q.push_back({8'(i), 8'(s[j])});
      exp_q.push_back({8'(j), 8'(s[i])});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = 8'(s[n]);
  endfunction

  // Monitor: every DUT write must match the next predicted write.
  always @(negedge clock) begin
    if (wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write at %0t",
                 address, data, $time);
      end else begin
        check("write_addr_data", {16'd0, address, data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Caller raises start so that the next rising edge is E0.
  task automatic do_run(input bit chk_fill, input int drop_at);
    int bad;
    bit seen [256];
    for (int e = 0; e <= 1792; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 0) begin
        check("fill_first_wren", 32'(wren), 32'd1);
        check("fill_first_addr", 32'(address), 32'd0);
      end
      if (chk_fill && e == 256) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== 8'(n)) bad++;
        check("fill_identity_bad", 32'(bad), 32'd0);
      end
      if (e == drop_at) start = 1'b0;
      if (e == 1791) check("done_not_early", 32'(done), 32'd0);
    end
    check("done_at_1793", 32'(done), 32'd1);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
    check("final_mem_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) seen[n] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      if (^mem[n] === 1'bx) bad++;
      else seen[mem[n]] = 1'b1;
    end
    for (int n = 0; n < 256; n++) if (!seen[n]) bad++;
    check("permutation_bad", 32'(bad), 32'd0);
  endtask

  task automatic new_run(input logic [23:0] key);
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1;
    secret_key = key;
    push_run(key);
    start = 1'b1;
  endtask

  initial begin
    logic [23:0] rk;
    reset_n    = 1'b0;
    start      = 1'b1;
    secret_key = 24'h000000;

    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wren", 32'(wren), 32'd0);
      check("rst_addr", 32'(address), 32'd0);
    end

    // Key 0: self-swaps at i=0,1 and the 2<->3 swap at i=2 are in the stream.
    push_run(24'h000000);
    reset_n = 1'b1;
    do_run(1'b1, -1);

    repeat (50) begin
      @(posedge clock);
      @(negedge clock);
      check("done_hold", 32'(done), 32'd1);
    end
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("idle_done", 32'(done), 32'd0);
    check("idle_wren", 32'(wren), 32'd0);

    @(posedge clock); #1;
    secret_key = 24'h4A2F91;
    push_run(24'h4A2F91);
    start = 1'b1;
    do_run(1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom());
      new_run(rk);
      do_run(1'b0, (r == 1) ? 600 : -1);
    end

    // Reset in the middle of the swap loop, then a clean run.
    new_run(24'($urandom()));
    repeat (901) @(posedge clock);
    #1;
    reset_n = 1'b0;
    start   = 1'b0;
    @(posedge clock); #1;
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
    check("midrst_wren", 32'(wren), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", 32'(address), 32'd0);
    @(posedge clock); #1;
    rk = 24'($urandom());
    secret_key = rk;
    push_run(rk);
    start = 1'b1;
    do_run(1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

RC4 key-scheduling engine, started and monitored by the lab controller FSM through its `startTask1` / `stopTask1` handshake. On start it initialises the 256-byte S working memory to the identity permutation. It then runs the RC4 key-scheduling swap loop using a 24-bit secret key and signals completion. It is the sole master of the S memory port while running.

## Interface
Parameters:
- `KEY_BYTES`, 3: secret key length in bytes; the key is consumed most-significant byte first.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  driven by the controller's `startTask1`; request level.
- `done`  out  1  drives the controller's `stopTask1`; completion level.
- `secret_key`  in  24  key; must be held stable from start accepted until done.
- `address`  out  8  S memory address.
- `data`  out  8  S memory write data.
- `wren`  out  1  S memory write enable.
- `q`  in  8  S memory read data; synchronous RAM with 1-cycle read latency.

## Operation
- States: IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE.
- **IDLE**
  - Outputs `wren`=0 and `done`=0.
  - `start`=1 at an edge moves the engine to FILL with i=0 and j=0.
- **FILL**
  - Drives `address`=i, `data`=i, `wren`=1 for one cycle per value.
  - i increments each cycle.
  - After the write of i=255, goes to RD_I with i=0 and key index k=0.
- **RD_I**: `address`=i, `wren`=0.
- **CAP_I**
  - Latches si=q.
  - Updates j ← (j + si + key[k]) mod 256.
- **RD_J**: `address`=j, `wren`=0.
- **CAP_J**: latches sj=q.
- **WR_I**: `address`=i, `data`=sj, `wren`=1.
- **WR_J**
  - Drives `address`=j, `data`=si, `wren`=1.
  - If i=255, goes to DONE.
  - Otherwise increments i and k, wrapping k from KEY_BYTES-1 to 0, and goes to RD_I.
- **Key byte selection**
  - key[0]=`secret_key[23:16]`, key[1]=`[15:8]`, key[2]=`[7:0]`.
  - k is a modulo-KEY_BYTES counter; no divider is used.
- **DONE**
  - `done`=1 and `wren`=0.
  - Stays in DONE while `start`=1.
  - Returns to IDLE on the first edge with `start`=0 (4-phase handshake).
- **Arithmetic**: i and j are 8-bit and wrap modulo 256; sums are truncated to 8 bits.
- **Boundary conditions**
  - i==j: both writes go to the same address with equal data (si==sj, since no write occurs between the two reads). The result is correct with no special case.
  - `start` deasserted during FILL or swap: ignored; the run completes.
  - `start` held high after DONE: no restart. A new run requires `start` low for at least one edge, then high again.
  - Reset mid-run: the next edge with `reset_n`=0 forces IDLE and clears i, j, k. Memory contents are left partial, and no further writes occur.

## Timing
- **Reset values**: state=IDLE, `done`=0, `wren`=0, `address`=0, `data`=0.
- Outputs are decoded from registered state, counters and latches. They are valid for the full cycle of each state, with no combinational path from `q` or `start` to the outputs.
- **Cycle budget** (edge E0 = the edge that samples `start`=1 in IDLE):
  - FILL occupies cycles 1–256.
  - The swap loop takes 6 cycles per i and occupies cycles 257–1792.
  - `done`=1 from cycle 1793.
  - Total latency: 1792 cycles.
- The read data for RD_I / RD_J is sampled at the end of the following cycle (CAP_I / CAP_J), matching the 1-cycle RAM latency.
- Exactly 768 writes occur per run: 256 fill plus 512 swap.

## Test plan
- **Reset**: hold `reset_n`=0 for 3 cycles with `start`=1 → `done`=0, `wren`=0, `address`=0 throughout; no writes.
- **Fill**: `start`=1 with a RAM model attached → cycles 1–256 write addr n with data n. At cycle 256, mem[n]=n for all n.
- **Key 0x000000, first iterations**
  - i=0: j=0, writes mem[0]=0 twice (self-swap).
  - i=1: j=1, self-swap.
  - i=2: j=3, writes addr 2 data 3, then addr 3 data 2.
- **Full run with key 0x4A2F91**
  - Final memory equals a software RC4 KSA model byte-for-byte.
  - `done` rises at cycle 1793 and the memory is a permutation of 0..255.
- **Handshake**: keep `start` high for 50 cycles after `done` → `done` stays 1 with no writes. Drop `start` → IDLE next edge, `done`=0. Raising `start` again → a new FILL starts the following cycle.
- **Mid-run reset**: assert `reset_n`=0 at cycle 900 for one edge → next cycle `wren`=0, `done`=0, state IDLE. A subsequent `start` completes a full correct run in 1792 cycles.
